// File: rtl/uart_pkg.sv
// uart_pkg: shared constants and FSM state encoding for the UART transmit feeder.
`default_nettype none
package uart_pkg;
   localparam int BYTE_W        = 8;
   localparam int DEFAULT_DEPTH = 16;

   typedef enum logic {
      IDLE = 1'b0,
      BUSY = 1'b1
   } state_t;
endpackage
`default_nettype wire

// File: rtl/uart_byte_fifo.sv
// uart_byte_fifo: first-word fall-through byte FIFO; full/empty come from the occupancy count.
`default_nettype none
module uart_byte_fifo
   import uart_pkg::*;
#(
   parameter int DEPTH  = DEFAULT_DEPTH,
   parameter int ADDR_W = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              wr_en,
   input  logic [BYTE_W-1:0] wr_data,
   input  logic              rd_en,
   output logic [BYTE_W-1:0] rd_data,
   output logic [ADDR_W:0]   count,
   output logic              full,
   output logic              empty
);
   localparam logic [ADDR_W:0]   CNT_FULL = DEPTH[ADDR_W:0];
   localparam logic [ADDR_W:0]   CNT_ONE  = {{ADDR_W{1'b0}}, 1'b1};
   localparam logic [ADDR_W-1:0] PTR_ONE  = {{(ADDR_W-1){1'b0}}, 1'b1};

   logic [BYTE_W-1:0] mem [DEPTH];
   logic [ADDR_W-1:0] wptr;
   logic [ADDR_W-1:0] rptr;
   logic              wr_accept;
   logic              rd_accept;

   assign full      = (count == CNT_FULL);
   assign empty     = (count == '0);
   // A pop frees a slot in the same cycle, so a write at full is still taken.
   assign wr_accept = wr_en && (!full || rd_accept);
   assign rd_accept = rd_en && !empty;
   assign rd_data   = mem[rptr];

   always_ff @(posedge clk) begin
      if (wr_accept) begin
         mem[wptr] <= wr_data;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wptr  <= '0;
         rptr  <= '0;
         count <= '0;
      end else begin
         if (wr_accept) begin
            wptr <= wptr + PTR_ONE;
         end
         if (rd_accept) begin
            rptr <= rptr + PTR_ONE;
         end
         case ({wr_accept, rd_accept})
            2'b10:   count <= count + CNT_ONE;
            2'b01:   count <= count - CNT_ONE;
            default: count <= count;
         endcase
      end
   end
endmodule
`default_nettype wire

// File: rtl/uart_tx_feeder.sv
// uart_tx_feeder: buffers host bytes and feeds them back-to-back to the UART transmit stage.
`default_nettype none
module uart_tx_feeder
   import uart_pkg::*;
#(
   parameter int DEPTH  = DEFAULT_DEPTH,
   parameter int ADDR_W = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              wr_en,
   input  logic [BYTE_W-1:0] wr_data,
   output logic              full,
   output logic              empty,
   output logic [ADDR_W:0]   count,
   output logic              overflow,
   input  logic              clr_ovf,
   output logic              tx_en_sig,
   output logic [BYTE_W-1:0] tx_data,
   input  logic              tx_done_sig
);
   state_t            state;
   state_t            state_next;
   logic              pop;
   logic              drop;
   logic [BYTE_W-1:0] head;

   uart_byte_fifo #(
      .DEPTH  (DEPTH),
      .ADDR_W (ADDR_W)
   ) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .wr_en   (wr_en),
      .wr_data (wr_data),
      .rd_en   (pop),
      .rd_data (head),
      .count   (count),
      .full    (full),
      .empty   (empty)
   );

   assign drop      = wr_en && full && !pop;
   assign tx_en_sig = (state == BUSY);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next = state;
      pop        = 1'b0;
      case (state)
         IDLE: begin
            if (!empty) begin
               pop        = 1'b1;
               state_next = BUSY;
            end
         end
         BUSY: begin
            // Pre-edge empty decides: a byte written this cycle waits for IDLE.
            if (tx_done_sig) begin
               if (!empty) begin
                  pop = 1'b1;
               end else begin
                  state_next = IDLE;
               end
            end
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         tx_data  <= '0;
         overflow <= 1'b0;
      end else begin
         if (pop) begin
            tx_data <= head;
         end
         if (drop) begin
            overflow <= 1'b1;
         end else if (clr_ovf) begin
            overflow <= 1'b0;
         end
      end
   end
endmodule
`default_nettype wire
